// File: rtl/obj_pkg.sv
// ---------------------------------------------------------------------------
// obj_pkg
// Shared definitions for the object row scanner:
//   - object shape / size encodings as found in attribute words 0 and 1
//   - scanner FSM state type and state constants
//   - obj_vsize(): vertical extent of an object in scanlines
// ---------------------------------------------------------------------------
package obj_pkg;

    localparam int unsigned IDX_W = 7;

    typedef enum logic [1:0] {
        SHAPE_SQUARE = 2'd0,
        SHAPE_WIDE   = 2'd1,
        SHAPE_TALL   = 2'd2,
        SHAPE_RSVD   = 2'd3
    } obj_shape_e;

    typedef enum logic [1:0] {
        SIZE_0 = 2'd0,
        SIZE_1 = 2'd1,
        SIZE_2 = 2'd2,
        SIZE_3 = 2'd3
    } obj_size_e;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t ST_IDLE  = 2'd0;
    localparam scan_state_t ST_READ  = 2'd1;
    localparam scan_state_t ST_EVAL  = 2'd2;
    localparam scan_state_t ST_DRAIN = 2'd3;

    // Base height from shape/size; affine double-size objects span twice the
    // lines. The largest result (64 doubled) is 128, which still fits 8 bits.
    function automatic logic [7:0] obj_vsize(input obj_shape_e shape,
                                             input obj_size_e  size,
                                             input logic       affine,
                                             input logic       dbl);
        logic [7:0] base;
        base = 8'd8;
        case ({shape, size})
            4'b00_00: base = 8'd8;
            4'b00_01: base = 8'd16;
            4'b00_10: base = 8'd32;
            4'b00_11: base = 8'd64;
            4'b01_00: base = 8'd8;
            4'b01_01: base = 8'd8;
            4'b01_10: base = 8'd16;
            4'b01_11: base = 8'd32;
            4'b10_00: base = 8'd16;
            4'b10_01: base = 8'd32;
            4'b10_10: base = 8'd32;
            4'b10_11: base = 8'd64;
            default:  base = 8'd8;
        endcase
        if (affine && dbl) begin
            base = {base[6:0], 1'b0};
        end else begin
            base = base;
        end
        return base;
    endfunction

endpackage

// File: rtl/obj_idx_fifo.sv
// ---------------------------------------------------------------------------
// obj_idx_fifo
// Small synchronous queue of object indices with a registered head.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : request to enqueue push_data
//   push_data    : value to enqueue
//   push_ok      : push will be taken this cycle (not full, or popping)
//   pop          : dequeue request (ignored when empty)
//   out_valid    : queue not empty (registered)
//   out_data     : current head (registered)
// DEPTH must be a power of two, at least 2, so pointers wrap naturally.
// ---------------------------------------------------------------------------
module obj_idx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ok,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             valid_r;
    logic [WIDTH-1:0] head_r;

    logic             pop_s;
    logic             push_s;
    logic             full_s;
    logic [CNT_W-1:0] cnt_after_pop_s;
    logic [CNT_W-1:0] count_next_s;
    logic [PTR_W-1:0] rd_next_s;
    logic [WIDTH-1:0] head_next_s;

    // Occupancy, handshake and next-head computation. A pop frees a slot in
    // the same cycle, so a full queue can accept a simultaneous push.
    always_comb begin
        pop_s           = pop && valid_r;
        full_s          = (count_r == CNT_W'(DEPTH));
        push_ok         = !full_s || pop_s;
        push_s          = push && push_ok;
        cnt_after_pop_s = pop_s ? (count_r - CNT_W'(1)) : count_r;
        count_next_s    = push_s ? (cnt_after_pop_s + CNT_W'(1)) : cnt_after_pop_s;
        rd_next_s       = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        // The pushed value becomes the head only if nothing else remains.
        if (push_s && (cnt_after_pop_s == {CNT_W{1'b0}})) begin
            head_next_s = push_data;
        end else if (cnt_after_pop_s != {CNT_W{1'b0}}) begin
            head_next_s = mem_r[rd_next_s];
        end else begin
            head_next_s = {WIDTH{1'b0}};
        end
    end

    // Storage, pointers and registered head/valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= 1'b0;
            head_r   <= {WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            valid_r  <= (count_next_s != {CNT_W{1'b0}});
            head_r   <= head_next_s;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = head_r;

endmodule

// File: rtl/obj_row_scanner.sv
// ---------------------------------------------------------------------------
// obj_row_scanner
// Walks all 128 OAM entries for one scanline and queues, in ascending order,
// the indices of objects that overlap that line.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, row            : begin a scan of `row` (ignored while busy)
//   oam_rd, oam_idx       : OAM read strobe and entry index
//   oam_attr0, oam_attr1  : attribute words, valid one cycle after oam_rd
//   out_valid/out_ready   : handshake for out_idx
//   out_idx               : visible object index (queue head)
//   busy                  : scan in progress or queue not yet drained
//   done                  : one-cycle pulse at the end of a scan
//   num_visible           : indices enqueued during the current/last scan
// Build option: OBJ_DISABLE_SKIP_EN -- when defined, non-affine objects with
// the disable bit (attr0[9]) set are never reported.
// ---------------------------------------------------------------------------
module obj_row_scanner
    import obj_pkg::*;
#(
    parameter int MAX_OBJS   = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  row,
    output logic        oam_rd,
    output logic [6:0]  oam_idx,
    input  logic [15:0] oam_attr0,
    input  logic [15:0] oam_attr1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_idx,
    output logic        busy,
    output logic        done,
    output logic [7:0]  num_visible
);

    scan_state_t state_r;
    scan_state_t state_next_s;
    logic [6:0]  idx_r;
    logic [6:0]  idx_next_s;
    logic [7:0]  num_vis_r;
    logic [7:0]  row_r;
    logic        eval_first_r;
    logic [7:0]  objy_r;
    logic        affine_r;
    logic        dbl_r;
    logic [1:0]  shape_r;
    logic [1:0]  size_r;
    logic        oam_rd_r;
    logic [6:0]  oam_idx_r;
    logic        busy_r;
    logic        done_r;

    logic [7:0]  objy_s;
    logic        affine_s;
    logic        dbl_s;
    logic [1:0]  shape_s;
    logic [1:0]  size_s;
    logic [7:0]  vsize_s;
    logic [7:0]  upper_s;
    logic        visible_s;
    logic        want_push_s;
    logic        push_ok_s;
    logic        accept_s;
    logic        stall_s;
    logic        last_s;
    logic [7:0]  num_vis_cnt_s;
    logic        fifo_valid_s;
    logic        pop_s;
    logic        unused_attr_s;

    // Attribute bits that play no part in vertical visibility.
    assign unused_attr_s = ^{oam_attr0[13:10], oam_attr1[13:0]};

    // Attribute fields come straight off the bus in the first EVAL cycle and
    // from the latched copy while EVAL is stalled on a full queue.
    always_comb begin
        if (eval_first_r) begin
            objy_s   = oam_attr0[7:0];
            affine_s = oam_attr0[8];
            dbl_s    = oam_attr0[9];
            shape_s  = oam_attr0[15:14];
            size_s   = oam_attr1[15:14];
        end else begin
            objy_s   = objy_r;
            affine_s = affine_r;
            dbl_s    = dbl_r;
            shape_s  = shape_r;
            size_s   = size_r;
        end
    end

    // Vertical overlap in 8-bit arithmetic. An object whose top is in the
    // lower half and whose bottom wrapped into the upper half covers the
    // lines from 0 up to the wrapped bottom.
    always_comb begin
        vsize_s   = obj_vsize(obj_shape_e'(shape_s), obj_size_e'(size_s), affine_s, dbl_s);
        upper_s   = objy_s + vsize_s;
        visible_s = (row_r < upper_s) && ((objy_s[7] && !upper_s[7]) || (objy_s <= row_r));
`ifdef OBJ_DISABLE_SKIP_EN
        if (!affine_s && dbl_s) begin
            visible_s = 1'b0;
        end else begin
            visible_s = visible_s;
        end
`endif
    end

    // FSM next state, entry index and end-of-scan decision.
    always_comb begin
        want_push_s   = (state_r == ST_EVAL) && visible_s;
        accept_s      = want_push_s && push_ok_s;
        stall_s       = want_push_s && !push_ok_s;
        num_vis_cnt_s = accept_s ? (num_vis_r + 8'd1) : num_vis_r;
        last_s        = (idx_r == 7'd127) || (num_vis_cnt_s >= 8'(MAX_OBJS));
        state_next_s  = state_r;
        idx_next_s    = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_READ;
                    idx_next_s   = 7'd0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_next_s = ST_EVAL;
            end
            ST_EVAL: begin
                if (stall_s) begin
                    state_next_s = ST_EVAL;
                end else if (last_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_READ;
                    idx_next_s   = idx_r + 7'd1;
                end
            end
            ST_DRAIN: begin
                if (!fifo_valid_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Scanner state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= 7'd0;
            num_vis_r    <= 8'd0;
            row_r        <= 8'd0;
            eval_first_r <= 1'b0;
            objy_r       <= 8'd0;
            affine_r     <= 1'b0;
            dbl_r        <= 1'b0;
            shape_r      <= 2'd0;
            size_r       <= 2'd0;
            oam_rd_r     <= 1'b0;
            oam_idx_r    <= 7'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            idx_r        <= idx_next_s;
            eval_first_r <= (state_r == ST_READ);
            oam_rd_r     <= (state_next_s == ST_READ);
            oam_idx_r    <= idx_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
            done_r       <= (state_r == ST_DRAIN) && !fifo_valid_s;
            if ((state_r == ST_IDLE) && start) begin
                row_r     <= row;
                num_vis_r <= 8'd0;
            end else begin
                num_vis_r <= num_vis_cnt_s;
            end
            if (eval_first_r) begin
                objy_r   <= objy_s;
                affine_r <= affine_s;
                dbl_r    <= dbl_s;
                shape_r  <= shape_s;
                size_r   <= size_s;
            end
        end
    end

    assign pop_s = fifo_valid_s && out_ready;

    obj_idx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IDX_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (want_push_s),
        .push_data (idx_r),
        .push_ok   (push_ok_s),
        .pop       (pop_s),
        .out_valid (fifo_valid_s),
        .out_data  (out_idx)
    );

    assign out_valid   = fifo_valid_s;
    assign oam_rd      = oam_rd_r;
    assign oam_idx     = oam_idx_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign num_visible = num_vis_r;

endmodule

// File: tb/tb_obj_row_scanner.sv
// ---------------------------------------------------------------------------
// tb_obj_row_scanner
// Directed bench for obj_row_scanner (MAX_OBJS=32, FIFO_DEPTH=4). An OAM
// model answers each read one cycle later and drives an invisible object
// pattern at all other times, so stalled evaluations must use latched data.
// ---------------------------------------------------------------------------
module tb_obj_row_scanner;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  row;
    logic        oam_rd;
    logic [6:0]  oam_idx;
    logic [15:0] oam_attr0;
    logic [15:0] oam_attr1;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_idx;
    logic        busy;
    logic        done;
    logic [7:0]  num_visible;

    int          n_cmp;
    int          n_err;
    logic [15:0] mem0 [128];
    logic [15:0] mem1 [128];
    logic [6:0]  got [$];
    logic        pend;
    logic [6:0]  pidx;

    obj_row_scanner #(
        .MAX_OBJS   (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .row         (row),
        .oam_rd      (oam_rd),
        .oam_idx     (oam_idx),
        .oam_attr0   (oam_attr0),
        .oam_attr1   (oam_attr1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .busy        (busy),
        .done        (done),
        .num_visible (num_visible)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture read requests away from the clock edge.
    always @(negedge clk) begin
        pend = oam_rd;
        pidx = oam_idx;
    end

    // Present read data for exactly the cycle after oam_rd; otherwise drive a
    // shape-3 object 64 lines below the row, which is never visible.
    always @(posedge clk) begin
        #1;
        if (pend) begin
            oam_attr0 = mem0[pidx];
            oam_attr1 = mem1[pidx];
        end else begin
            oam_attr0 = {2'b11, 6'd0, row + 8'd64};
            oam_attr1 = 16'h0000;
        end
    end

    // Consumer side: record every accepted index.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got.push_back(out_idx);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_all(input logic [15:0] a0, input logic [15:0] a1);
        for (int k = 0; k < 128; k++) begin
            mem0[k] = a0;
            mem1[k] = a1;
        end
    endtask

    function automatic int got_at(input int k);
        if (got.size() > k) return int'(got[k]);
        else return -1;
    endfunction

    // Run one scan with the consumer always ready; optionally pulse start
    // again at cycle poke_at, which must be ignored.
    task automatic do_scan(input logic [7:0] r, input int poke_at, output int lat);
        got.delete();
        out_ready = 1'b1;
        @(negedge clk);
        row   = r;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 3000) begin
            @(negedge clk);
            lat++;
            start = (lat == poke_at);
            if (lat == 100) chk("busy_mid_scan", busy, 1);
        end
        start = 1'b0;
        chk("scan_timeout", lat < 3000, 1);
        chk("busy_at_done", busy, 0);
    endtask

    initial begin
        int lat;
        int cnt;
        int exp_n;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        row       = 8'd0;
        out_ready = 1'b1;
        oam_attr0 = 16'h0000;
        oam_attr1 = 16'h0000;
        pend      = 1'b0;
        pidx      = 7'd0;
        fill_all(16'h00A0, 16'h0000);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {oam_rd, oam_idx, out_valid, out_idx, busy, done, num_visible}, 0);
        rst_n = 1'b1;

        // Single visible entry 5 (objy 16, 8 lines) on row 20, with a stray
        // start mid-scan that must not restart it.
        mem0[5] = 16'h0010;
        do_scan(8'd20, 50, lat);
        chk("single_count", got.size(), 1);
        chk("single_idx", got_at(0), 5);
        chk("single_numvis", num_visible, 1);
        chk("single_latency", (lat >= 255) && (lat <= 260), 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        // Wrapped object: objy 250, 16 lines -> covers 250..255 and 0..9
        fill_all(16'h00A0, 16'h0000);
        mem0[0] = 16'h00FA;
        mem1[0] = 16'h4000;
        do_scan(8'd2, 0, lat);
        chk("wrap_row2_count", got.size(), 1);
        chk("wrap_row2_idx", got_at(0), 0);
        do_scan(8'd10, 0, lat);
        chk("wrap_row10_count", got.size(), 0);
        chk("wrap_row10_numvis", num_visible, 0);

        // Affine double size, tall 64 -> 128 lines from objy 0
        fill_all(16'h00A0, 16'h0000);
        mem0[3] = 16'h8300;
        mem1[3] = 16'hC000;
        do_scan(8'd127, 0, lat);
        chk("dbl_row127_count", got.size(), 1);
        chk("dbl_row127_idx", got_at(0), 3);
        do_scan(8'd128, 0, lat);
        chk("dbl_row128_count", got.size(), 0);

        // Non-affine object with the disable bit set
        fill_all(16'h00A0, 16'h0000);
        mem0[7] = 16'h0210;
`ifdef OBJ_DISABLE_SKIP_EN
        exp_n = 0;
`else
        exp_n = 1;
`endif
        do_scan(8'd20, 0, lat);
        chk("disable_count", got.size(), exp_n);
        chk("disable_numvis", num_visible, exp_n);

        // All entries visible (objy 0, 64 lines), consumer stalled 100 cycles
        fill_all(16'h0000, 16'hC000);
        got.delete();
        out_ready = 1'b0;
        @(negedge clk);
        row   = 8'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("stall_valid", out_valid, 1);
        chk("stall_head", out_idx, 0);
        chk("stall_numvis", num_visible, 4);
        chk("stall_oam_idx", oam_idx, 4);
        chk("stall_busy", busy, 1);
        out_ready = 1'b1;
        cnt = 0;
        while (!done && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("stall_timeout", cnt < 2000, 1);
        chk("stall_count", got.size(), 32);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("stall_order_%0d", k), got_at(k), k);
        end
        chk("stall_numvis_end", num_visible, 32);
        chk("stall_last_read", oam_idx, 31);

        // Every 4th entry visible; reset when entry 40 is being read
        fill_all(16'h00A0, 16'h0000);
        for (int k = 0; k < 128; k += 4) begin
            mem0[k] = 16'h0000;
            mem1[k] = 16'hC000;
        end
        got.delete();
        @(negedge clk);
        row   = 8'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        while (!(oam_rd && oam_idx == 7'd40) && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst_reach_40", cnt < 1000, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {oam_rd, oam_idx, out_valid, out_idx, busy, done, num_visible}, 0);
        repeat (2) @(negedge clk);
        got.delete();
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_rd", oam_rd, 1);
        chk("restart_idx0", oam_idx, 0);
        cnt = 0;
        while (!done && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("restart_timeout", cnt < 2000, 1);
        chk("restart_count", got.size(), 32);
        chk("restart_first", got_at(0), 0);
        chk("restart_last", got_at(31), 124);
        chk("restart_numvis", num_visible, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
